regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised multi-port register file with a per-register scoreboard. It replaces the fixed 16x16 two-read/one-write file in the decode stage, and it serves as the operand source for the pipelined core. Features:
- Configurable width, depth and read-port count.
- Two write ports with fixed priority.
- Enable-qualified write-to-read bypass on data and busy status.
- Pending-write (busy) bit per register, plus a live count of busy registers for hazard/stall logic.

## Interface
Parameters:
- WIDTH, 16, data bits per register
- DEPTH, 16, number of registers; power of two, >= 2; AW = $clog2(DEPTH)
- NUM_RD, 2, number of read ports, 1..4
- ZERO_REG, 0, 1 = register 0 hardwired to zero (reads 0, writes/issues ignored, never busy)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_RD*AW  read addresses, port p at [p*AW +: AW]
- rd_data  out  NUM_RD*WIDTH  read data, port p at [p*WIDTH +: WIDTH]
- rd_busy  out  NUM_RD  busy status of each read address
- wr_en  in  2  write enables, ports 0 and 1
- wr_addr  in  2*AW  write addresses
- wr_data  in  2*WIDTH  write data
- iss_en  in  1  issue: mark iss_addr busy (pending writeback)
- iss_addr  in  AW  destination register of issuing instruction
- busy_cnt  out  $clog2(DEPTH+1)  number of registers currently busy

## Operation
- Storage: DEPTH x WIDTH flops, busy vector DEPTH bits, busy_cnt register.
- Write: on clk rise, each wr_en[i] writes wr_data[i] to wr_addr[i].
- Collision: both write ports to the same address in one cycle -> port 1 wins.
- Read: combinational per port.
  - If some wr_en[i] && wr_addr[i] == rd_addr[p], rd_data[p] = that wr_data (port 1 over port 0).
  - Otherwise rd_data[p] = stored value.
  - Bypass requires wr_en; a matching address with wr_en low does not bypass.
- ZERO_REG=1: reads of address 0 return 0 regardless of bypass; writes, issues and busy updates to address 0 are ignored.
- Scoreboard, per register r, next busy:
  - iss_en && iss_addr==r -> 1 (issue wins over a same-cycle write to r);
  - else any wr_en[i] && wr_addr[i]==r -> 0;
  - else hold.
- rd_busy[p] = busy[rd_addr[p]] && !(any enabled write to rd_addr[p] this cycle).
  - A same-cycle issue does not affect rd_busy until the next cycle.
- busy_cnt: registered count of set busy bits, updated each cycle by net delta in the range -2..+1.
  - Maintained incrementally, not by popcount, but must always equal the popcount of busy.
  - Never wraps: valid range 0..DEPTH.
- A write to a non-busy register is legal: data is written, busy stays 0, busy_cnt unchanged.
- Issue to an already busy register: busy stays 1, busy_cnt unchanged.

## Timing
- Reset (rst low, asynchronous): all registers 0, busy all 0, busy_cnt 0.
  - rd_data shows 0 for unbypassed reads; rd_busy 0.
  - Reset asserted mid-operation overrides same-cycle writes/issues.
  - First write is accepted on the first rising edge after rst deasserts.
- Write latency: 0 cycles via bypass, 1 cycle via storage (visible on the edge after the write).
- Read latency: 0 cycles, purely combinational from rd_addr, wr_*.
- Issue latency: busy bit and busy_cnt update on the edge of the issue; rd_busy reflects it from the next cycle.
- No handshake; all inputs sampled every cycle; no back-pressure.

## Test plan
- Reset: drive writes, assert rst low mid-cycle -> immediately all rd_data 0, rd_busy 0, busy_cnt 0; after release, read r5 = 0.
- Bypass and priority: wr_en=2'b11, both to r3 with 0xAAAA/0x5555, rd_addr p0=r3 -> rd_data 0x5555 same cycle, r3 = 0x5555 next cycle. Then wr_en=0 with wr_addr=r3, data 0x1234 -> no bypass, read 0x5555.
- Scoreboard: issue r7 -> busy_cnt 1, rd_busy 1 next cycle. Write r7 with 0xBEEF -> same cycle rd_busy 0, rd_data 0xBEEF; next cycle busy_cnt 0.
- Issue/write collision: r9 busy, same cycle iss_addr=r9 and wr_addr[0]=r9 -> r9 still busy, data updated, busy_cnt unchanged.
- Count limits: issue all DEPTH registers -> busy_cnt=16. Two writebacks in one cycle -> 14. Write to non-busy register -> unchanged, no wrap.
- ZERO_REG=1: write 0xFFFF and issue to r0 -> rd_data 0, rd_busy 0, busy_cnt 0. Run NUM_RD=4 and DEPTH=32, WIDTH=32 configs with random traffic against a reference model.

Source files
------------

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-port register file with write bypass and pending-write scoreboard
module regfile_sb #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 16,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 0,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]       rd_busy,
    input  logic [1:0]              wr_en,
    input  logic [2*AW-1:0]         wr_addr,
    input  logic [2*WIDTH-1:0]      wr_data,
    input  logic                    iss_en,
    input  logic [AW-1:0]           iss_addr,
    output logic [CW-1:0]           busy_cnt
);

    logic [AW-1:0]    wa0, wa1;
    logic [WIDTH-1:0] wd0, wd1;
    logic             we0, we1, ie;
    logic             inc, dec0, dec1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;

    // True when the address is the hardwired zero register in this configuration.
    function automatic logic is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign wa0 = wr_addr[0 +: AW];
    assign wa1 = wr_addr[AW +: AW];
    assign wd0 = wr_data[0 +: WIDTH];
    assign wd1 = wr_data[WIDTH +: WIDTH];

    // Writes and issues to the zero register are dropped before they reach any state.
    assign we0 = wr_en[0] && !is_zero(wa0);
    assign we1 = wr_en[1] && !is_zero(wa1);
    assign ie  = iss_en && !is_zero(iss_addr);

    // Storage update; port 1 is applied last so it wins an address collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem[r] <= '0;
            end
        end else begin
            if (we0) begin
                mem[wa0] <= wd0;
            end
            if (we1) begin
                mem[wa1] <= wd1;
            end
        end
    end

    // Next busy vector: writebacks clear, then an issue to the same register sets it again.
    always_comb begin
        busy_nxt = busy;
        if (we0) begin
            busy_nxt[wa0] = 1'b0;
        end
        if (we1) begin
            busy_nxt[wa1] = 1'b0;
        end
        if (ie) begin
            busy_nxt[iss_addr] = 1'b1;
        end
    end

    // Busy bit register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Count deltas: only real 0->1 and 1->0 transitions move the count. A register
    // written by both ports is cleared once, and a same-cycle issue cancels its clear.
    assign inc  = ie && !busy[iss_addr];
    assign dec0 = we0 && busy[wa0] && !(ie && (iss_addr == wa0));
    assign dec1 = we1 && busy[wa1] && !(ie && (iss_addr == wa1))
                  && !(we0 && (wa0 == wa1));

    // Incrementally maintained busy count, always equal to the number of set busy bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_cnt <= '0;
        end else begin
            busy_cnt <= busy_cnt + CW'(inc) - CW'(dec0) - CW'(dec1);
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0]    ra;
        logic             hit0, hit1;
        logic [WIDTH-1:0] data;

        assign ra   = rd_addr[p*AW +: AW];
        assign hit0 = wr_en[0] && (wa0 == ra);
        assign hit1 = wr_en[1] && (wa1 == ra);

        // Read mux: stored value, overridden by an enabled write (port 1 first), forced to zero for r0.
        always_comb begin
            data = mem[ra];
            if (hit1) begin
                data = wd1;
            end else if (hit0) begin
                data = wd0;
            end
            if (is_zero(ra)) begin
                data = '0;
            end
        end

        assign rd_data[p*WIDTH +: WIDTH] = data;
        // A writeback landing this cycle makes the register ready to the reader right away.
        assign rd_busy[p] = busy[ra] && !(hit0 || hit1);
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed and model-based checks for regfile_sb
module tb_regfile_sb;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Instance A: default 16x16, two read ports, r0 writable
    logic [7:0]  a_rd_addr;
    logic [31:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic [1:0]  a_wr_en;
    logic [7:0]  a_wr_addr;
    logic [31:0] a_wr_data;
    logic        a_iss_en;
    logic [3:0]  a_iss_addr;
    logic [4:0]  a_busy_cnt;

    regfile_sb #(.WIDTH(16), .DEPTH(16), .NUM_RD(2), .ZERO_REG(0)) u_a (
        .clk(clk), .rst(rst), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .iss_en(a_iss_en), .iss_addr(a_iss_addr), .busy_cnt(a_busy_cnt)
    );

    // Instance B: default sizes with hardwired zero register
    logic [7:0]  b_rd_addr;
    logic [31:0] b_rd_data;
    logic [1:0]  b_rd_busy;
    logic [1:0]  b_wr_en;
    logic [7:0]  b_wr_addr;
    logic [31:0] b_wr_data;
    logic        b_iss_en;
    logic [3:0]  b_iss_addr;
    logic [4:0]  b_busy_cnt;

    regfile_sb #(.WIDTH(16), .DEPTH(16), .NUM_RD(2), .ZERO_REG(1)) u_b (
        .clk(clk), .rst(rst), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .iss_en(b_iss_en), .iss_addr(b_iss_addr), .busy_cnt(b_busy_cnt)
    );

    // Instance C: 32x32, four read ports, zero register, random traffic
    logic [19:0]  c_rd_addr;
    logic [127:0] c_rd_data;
    logic [3:0]   c_rd_busy;
    logic [1:0]   c_wr_en;
    logic [9:0]   c_wr_addr;
    logic [63:0]  c_wr_data;
    logic         c_iss_en;
    logic [4:0]   c_iss_addr;
    logic [5:0]   c_busy_cnt;

    regfile_sb #(.WIDTH(32), .DEPTH(32), .NUM_RD(4), .ZERO_REG(1)) u_c (
        .clk(clk), .rst(rst), .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_busy(c_rd_busy),
        .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
        .iss_en(c_iss_en), .iss_addr(c_iss_addr), .busy_cnt(c_busy_cnt)
    );

    typedef struct {
        logic [1:0]  we;
        logic [3:0]  wa0, wa1;
        logic [15:0] wd0, wd1;
        logic        ie;
        logic [3:0]  ia;
        logic [3:0]  ra0, ra1;
        logic [15:0] e_rd0, e_rd1;
        logic [1:0]  e_busy;
        logic [4:0]  e_cnt;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(input logic [1:0] we, input logic [3:0] wa0, input logic [3:0] wa1,
                                input logic [15:0] wd0, input logic [15:0] wd1,
                                input logic ie, input logic [3:0] ia,
                                input logic [3:0] ra0, input logic [3:0] ra1,
                                input logic [15:0] e0, input logic [15:0] e1,
                                input logic [1:0] eb, input logic [4:0] ec);
        vec_t v;
        v.we = we; v.wa0 = wa0; v.wa1 = wa1; v.wd0 = wd0; v.wd1 = wd1;
        v.ie = ie; v.ia = ia; v.ra0 = ra0; v.ra1 = ra1;
        v.e_rd0 = e0; v.e_rd1 = e1; v.e_busy = eb; v.e_cnt = ec;
        return v;
    endfunction

    task automatic a_drive(input logic [1:0] we, input logic [3:0] wa0, input logic [3:0] wa1,
                           input logic [15:0] wd0, input logic [15:0] wd1,
                           input logic ie, input logic [3:0] ia,
                           input logic [3:0] ra0, input logic [3:0] ra1);
        a_wr_en    = we;
        a_wr_addr  = {wa1, wa0};
        a_wr_data  = {wd1, wd0};
        a_iss_en   = ie;
        a_iss_addr = ia;
        a_rd_addr  = {ra1, ra0};
    endtask

    task automatic a_idle(input logic [3:0] ra0, input logic [3:0] ra1);
        a_drive(2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 1'b0, 4'd0, ra0, ra1);
    endtask

    function automatic logic [4:0] pick();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 3));
        return 5'($urandom_range(0, 31));
    endfunction

    logic [31:0]  m_mem [32];
    logic [31:0]  m_bsy;
    logic [127:0] e_data;
    logic [3:0]   e_bsy;
    logic [4:0]   ra, w0, w1;
    logic [31:0]  ed;
    int           pc;

    initial begin
        rst = 1'b0;
        a_drive(2'b11, 4'd5, 4'd6, 16'h1111, 16'h2222, 1'b1, 4'd7, 4'd1, 4'd2);
        b_wr_en = 2'b00; b_wr_addr = '0; b_wr_data = '0; b_iss_en = 1'b0; b_iss_addr = '0; b_rd_addr = '0;
        c_wr_en = 2'b00; c_wr_addr = '0; c_wr_data = '0; c_iss_en = 1'b0; c_iss_addr = '0; c_rd_addr = '0;
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        m_bsy = '0;

        // Reset state while writes are being driven
        #1;
        chk("reset rd_data", 128'(a_rd_data), 128'(0));
        chk("reset rd_busy", 128'(a_rd_busy), 128'(0));
        chk("reset busy_cnt", 128'(a_busy_cnt), 128'(0));
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        a_idle(4'd5, 4'd6);
        rst = 1'b1;
        #1;
        chk("post-reset r5", 128'(a_rd_data), 128'(0));

        tbl[0]  = mk(2'b11, 4'd3, 4'd3, 16'hAAAA, 16'h5555, 1'b0, 4'd0, 4'd3, 4'd5, 16'h5555, 16'h0000, 2'b00, 5'd0);
        tbl[1]  = mk(2'b00, 4'd3, 4'd0, 16'h1234, 16'h0000, 1'b0, 4'd0, 4'd3, 4'd3, 16'h5555, 16'h5555, 2'b00, 5'd0);
        tbl[2]  = mk(2'b01, 4'd4, 4'd4, 16'h0444, 16'h9999, 1'b0, 4'd0, 4'd4, 4'd3, 16'h0444, 16'h5555, 2'b00, 5'd0);
        tbl[3]  = mk(2'b10, 4'd5, 4'd5, 16'h7777, 16'h0555, 1'b0, 4'd0, 4'd5, 4'd4, 16'h0555, 16'h0444, 2'b00, 5'd0);
        tbl[4]  = mk(2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 1'b1, 4'd7, 4'd7, 4'd5, 16'h0000, 16'h0555, 2'b00, 5'd0);
        tbl[5]  = mk(2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 1'b0, 4'd0, 4'd7, 4'd0, 16'h0000, 16'h0000, 2'b01, 5'd1);
        tbl[6]  = mk(2'b01, 4'd7, 4'd0, 16'hBEEF, 16'h0000, 1'b0, 4'd0, 4'd7, 4'd7, 16'hBEEF, 16'hBEEF, 2'b00, 5'd1);
        tbl[7]  = mk(2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 1'b0, 4'd0, 4'd7, 4'd3, 16'hBEEF, 16'h5555, 2'b00, 5'd0);
        tbl[8]  = mk(2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 1'b1, 4'd9, 4'd9, 4'd7, 16'h0000, 16'hBEEF, 2'b00, 5'd0);
        tbl[9]  = mk(2'b01, 4'd9, 4'd0, 16'h0999, 16'h0000, 1'b1, 4'd9, 4'd9, 4'd9, 16'h0999, 16'h0999, 2'b00, 5'd1);
        tbl[10] = mk(2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 1'b0, 4'd0, 4'd9, 4'd7, 16'h0999, 16'hBEEF, 2'b01, 5'd1);
        tbl[11] = mk(2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 1'b1, 4'd9, 4'd9, 4'd2, 16'h0999, 16'h0000, 2'b01, 5'd1);
        tbl[12] = mk(2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 1'b0, 4'd0, 4'd9, 4'd2, 16'h0999, 16'h0000, 2'b01, 5'd1);
        tbl[13] = mk(2'b01, 4'd2, 4'd0, 16'h2222, 16'h0000, 1'b0, 4'd0, 4'd2, 4'd9, 16'h2222, 16'h0999, 2'b10, 5'd1);
        tbl[14] = mk(2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 1'b0, 4'd0, 4'd2, 4'd9, 16'h2222, 16'h0999, 2'b10, 5'd1);
        tbl[15] = mk(2'b10, 4'd0, 4'd9, 16'h0000, 16'h1999, 1'b0, 4'd0, 4'd9, 4'd9, 16'h1999, 16'h1999, 2'b00, 5'd1);
        tbl[16] = mk(2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 1'b0, 4'd0, 4'd9, 4'd3, 16'h1999, 16'h5555, 2'b00, 5'd0);

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            a_drive(tbl[i].we, tbl[i].wa0, tbl[i].wa1, tbl[i].wd0, tbl[i].wd1,
                    tbl[i].ie, tbl[i].ia, tbl[i].ra0, tbl[i].ra1);
            #1;
            chk($sformatf("vec%0d rd0", i), 128'(a_rd_data[15:0]), 128'(tbl[i].e_rd0));
            chk($sformatf("vec%0d rd1", i), 128'(a_rd_data[31:16]), 128'(tbl[i].e_rd1));
            chk($sformatf("vec%0d busy", i), 128'(a_rd_busy), 128'(tbl[i].e_busy));
            chk($sformatf("vec%0d cnt", i), 128'(a_busy_cnt), 128'(tbl[i].e_cnt));
        end

        // Count limits: fill, double writeback, non-busy write, same-address pair, issue+writeback
        for (int r = 0; r < 16; r++) begin
            @(negedge clk);
            a_drive(2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 1'b1, 4'(r), 4'd0, 4'd0);
        end
        @(negedge clk);
        a_idle(4'd0, 4'd15);
        #1;
        chk("full cnt", 128'(a_busy_cnt), 128'(16));
        chk("full busy", 128'(a_rd_busy), 128'(2'b11));
        @(negedge clk);
        a_drive(2'b11, 4'd1, 4'd2, 16'h1111, 16'h2222, 1'b0, 4'd0, 4'd1, 4'd2);
        #1;
        chk("dual wb busy", 128'(a_rd_busy), 128'(2'b00));
        @(negedge clk);
        a_idle(4'd1, 4'd3);
        #1;
        chk("dual wb cnt", 128'(a_busy_cnt), 128'(14));
        chk("dual wb busy next", 128'(a_rd_busy), 128'(2'b10));
        chk("dual wb data", 128'(a_rd_data[15:0]), 128'(16'h1111));
        @(negedge clk);
        a_drive(2'b01, 4'd1, 4'd0, 16'h0101, 16'h0, 1'b0, 4'd0, 4'd1, 4'd1);
        @(negedge clk);
        a_idle(4'd1, 4'd1);
        #1;
        chk("nonbusy wr cnt", 128'(a_busy_cnt), 128'(14));
        @(negedge clk);
        a_drive(2'b11, 4'd4, 4'd4, 16'h4000, 16'h4001, 1'b0, 4'd0, 4'd4, 4'd4);
        @(negedge clk);
        a_idle(4'd4, 4'd4);
        #1;
        chk("same addr pair cnt", 128'(a_busy_cnt), 128'(13));
        chk("same addr pair data", 128'(a_rd_data[15:0]), 128'(16'h4001));
        @(negedge clk);
        a_drive(2'b01, 4'd3, 4'd0, 16'h3333, 16'h0, 1'b1, 4'd1, 4'd1, 4'd3);
        @(negedge clk);
        a_idle(4'd1, 4'd3);
        #1;
        chk("iss+wb cnt", 128'(a_busy_cnt), 128'(13));
        chk("iss+wb busy", 128'(a_rd_busy), 128'(2'b01));
        for (int r = 0; r < 16; r++) begin
            @(negedge clk);
            a_drive(2'b01, 4'(r), 4'd0, 16'hD000 | 16'(r), 16'h0, 1'b0, 4'd0, 4'd0, 4'd0);
        end
        @(negedge clk);
        a_drive(2'b11, 4'd6, 4'd8, 16'h0606, 16'h0808, 1'b0, 4'd0, 4'd0, 4'd0);
        @(negedge clk);
        a_idle(4'd6, 4'd8);
        #1;
        chk("drained cnt no wrap", 128'(a_busy_cnt), 128'(0));
        chk("drained data", 128'(a_rd_data), 128'({16'h0808, 16'h0606}));

        // Zero register instance
        @(negedge clk);
        a_idle(4'd0, 4'd0);
        b_wr_en = 2'b11; b_wr_addr = 8'h00; b_wr_data = 32'hFFFF_FFFF;
        b_iss_en = 1'b1; b_iss_addr = 4'd0; b_rd_addr = 8'h00;
        #1;
        chk("zr bypass rd", 128'(b_rd_data), 128'(0));
        chk("zr bypass busy", 128'(b_rd_busy), 128'(0));
        @(negedge clk);
        b_wr_en = 2'b00; b_iss_en = 1'b0;
        #1;
        chk("zr rd", 128'(b_rd_data), 128'(0));
        chk("zr busy", 128'(b_rd_busy), 128'(0));
        chk("zr cnt", 128'(b_busy_cnt), 128'(0));
        @(negedge clk);
        b_wr_en = 2'b01; b_wr_addr = 8'h01; b_wr_data = 32'h0000_00AB;
        b_iss_en = 1'b1; b_iss_addr = 4'd2; b_rd_addr = 8'h01;
        #1;
        chk("zr r1 bypass", 128'(b_rd_data), 128'(32'h0000_00AB));
        @(negedge clk);
        b_wr_en = 2'b00; b_iss_en = 1'b0; b_rd_addr = 8'h21;
        #1;
        chk("zr r1 stored", 128'(b_rd_data), 128'(32'h0000_00AB));
        chk("zr r2 busy", 128'(b_rd_busy), 128'(2'b10));
        chk("zr r2 cnt", 128'(b_busy_cnt), 128'(1));

        // Random traffic on the wide instance against a behavioural model
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            for (int p = 0; p < 4; p++) c_rd_addr[p*5 +: 5] = pick();
            c_wr_en    = 2'($urandom_range(0, 3));
            w0         = pick();
            w1         = ($urandom_range(0, 3) == 0) ? w0 : pick();
            c_wr_addr  = {w1, w0};
            c_wr_data  = {$urandom(), $urandom()};
            c_iss_en   = ($urandom_range(0, 1) == 1);
            c_iss_addr = ($urandom_range(0, 3) == 0) ? w0 : pick();
            #1;
            for (int p = 0; p < 4; p++) begin
                ra = c_rd_addr[p*5 +: 5];
                ed = m_mem[ra];
                if (c_wr_en[0] && w0 == ra) ed = c_wr_data[31:0];
                if (c_wr_en[1] && w1 == ra) ed = c_wr_data[63:32];
                if (ra == 5'd0) ed = '0;
                e_data[p*32 +: 32] = ed;
                e_bsy[p] = m_bsy[ra] && !((c_wr_en[0] && w0 == ra) || (c_wr_en[1] && w1 == ra));
            end
            pc = 0;
            for (int r = 0; r < 32; r++) pc += int'(m_bsy[r]);
            chk($sformatf("rnd%0d data", cyc), c_rd_data, e_data);
            chk($sformatf("rnd%0d busy", cyc), 128'(c_rd_busy), 128'(e_bsy));
            chk($sformatf("rnd%0d cnt", cyc), 128'(c_busy_cnt), 128'(pc));
            if (c_wr_en[0] && w0 != 5'd0) m_mem[w0] = c_wr_data[31:0];
            if (c_wr_en[1] && w1 != 5'd0) m_mem[w1] = c_wr_data[63:32];
            if (c_wr_en[0]) m_bsy[w0] = 1'b0;
            if (c_wr_en[1]) m_bsy[w1] = 1'b0;
            if (c_iss_en && c_iss_addr != 5'd0) m_bsy[c_iss_addr] = 1'b1;
            m_bsy[0] = 1'b0;
        end
        @(negedge clk);
        c_wr_en = 2'b00; c_iss_en = 1'b0;

        // Asynchronous reset mid-cycle while writes and an issue are being driven
        @(negedge clk);
        a_drive(2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 1'b1, 4'd5, 4'd5, 4'd5);
        @(negedge clk);
        a_drive(2'b11, 4'd10, 4'd11, 16'hAAAA, 16'hBBBB, 1'b1, 4'd12, 4'd5, 4'd9);
        #1;
        chk("pre-reset busy", 128'(a_rd_busy), 128'(2'b01));
        chk("pre-reset data", 128'(a_rd_data), 128'({16'hD009, 16'hD005}));
        #1;
        rst = 1'b0;
        #1;
        chk("async reset data", 128'(a_rd_data), 128'(0));
        chk("async reset busy", 128'(a_rd_busy), 128'(0));
        chk("async reset cnt", 128'(a_busy_cnt), 128'(0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        a_idle(4'd10, 4'd12);
        #1;
        chk("after reset data", 128'(a_rd_data), 128'(0));
        chk("after reset cnt", 128'(a_busy_cnt), 128'(0));
        chk("after reset busy", 128'(a_rd_busy), 128'(0));
        @(negedge clk);
        a_drive(2'b01, 4'd5, 4'd0, 16'h00C5, 16'h0, 1'b0, 4'd0, 4'd5, 4'd0);
        @(negedge clk);
        a_idle(4'd5, 4'd0);
        #1;
        chk("first write after reset", 128'(a_rd_data[15:0]), 128'(16'h00C5));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
